alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational ALU.
- Data width is a parameter. The op set grows from 4 to 8 operations.
- Adds a valid/ready handshake on both sides, a 2-stage pipeline, an accumulator operand mode and a sticky overflow flag.
- Sits between the operand-issue logic and the result consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values are 2 or more.
- SHW, $clog2(WIDTH), derived localparam: shift-amount width taken from b[SHW-1:0].

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept an operand beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation select
- acc_sel  in  1  1 = use accumulator in place of a
- oe  in  1  output enable for y, sampled with the operands
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result; forced to 0 when the beat's oe was 0
- parity  out  1  XOR-reduce of the unmasked result
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- greater  out  1  unsigned A > B (effective operands)
- is_eq  out  1  A == B
- less  out  1  unsigned A < B
- ovf_sticky  out  1  set by any delivered overflow beat
- ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Op encoding:
  - 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR
  - 101 SHL (A << b[SHW-1:0]), 110 SHR logical, 111 PASS_A
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - overflow = signed overflow: operand sign bits agree (ADD) or differ (SUB) and the result sign differs from A.
- Stage 1 (S1) register holds a, b, op, acc_sel, oe and s1_valid.
- Stage 2 (S2) register holds y, all flags and s2_valid. Flags are computed combinationally at the S1→S2 transfer.
- Handshake:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - in_ready = s1_adv
  - Input transfer when in_valid & in_ready.
  - S1→S2 transfer when s1_valid & s2_adv.
  - out_valid = s2_valid.
  - Full throughput of 1 beat/cycle when out_ready = 1. Latency is 2 cycles from input acceptance to out_valid.
  - Under stall, S2 outputs and S1 contents hold stable. At most 2 beats are in flight. Beats are never dropped or reordered.
- Accumulator:
  - WIDTH-bit register, reset 0.
  - Loaded with the unmasked result on every S1→S2 transfer.
  - When acc_sel = 1, the effective A is the accumulator value at the moment of that beat's S1→S2 transfer. This equals the result of the immediately preceding beat, so back-to-back chaining has no hazard.
  - Compare flags use the effective A.
- oe = 0: y = 0 for that beat. Parity, flags and the accumulator still use the true result.
- ovf_sticky:
  - Set on an S2 output transfer (out_valid & out_ready) whose overflow = 1.
  - Cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- Reset, asynchronous, any time including mid-stall:
  - s1_valid, s2_valid, out_valid = 0; y and all flags = 0.
  - Accumulator = 0; ovf_sticky = 0.
  - in_ready = 1 from the first cycle after reset deassertion.
- Held outputs when out_valid = 0 are don't-care for checking. The implementation holds the last values.

Decomposition:
- Package alu_pipe_pkg holds:
  - op enum alu_op_e (ADD, SUB, AND, OR, XOR, SHL, SHR, PASS_A)
  - struct alu_flags_t {parity, overflow, greater, is_eq, less}
- One combinational sub-module, alu_core (params WIDTH): effective A, b, op → result and flags.
- Pipeline registers, handshake, accumulator and sticky logic live in alu_pipe.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 oe=1, out_ready=1 → 2 cycles later y=0x80, overflow=1, parity=1, less=0, greater=1; ovf_sticky=1 the cycle after delivery.
- SUB a=0x05 b=0x05 → y=0x00, is_eq=1, parity=0, overflow=0. Then SHL a=0x81 b=0x03 → y=0x08.
- Chain: ADD a=3 b=4, next cycle ADD acc_sel=1 b=10 → results 0x07 then 0x11, back-to-back with no bubble.
- Backpressure: out_ready=0 while issuing XOR beats 0x0F^0xF0 and 0xAA^0x55 plus a third → in_ready falls after 2 accepted and the third waits. out_ready=1 → 0xFF, 0xFF, then the third, in order; y holds stable during the stall.
- oe=0 with OR a=0x01 b=0x02 → y=0x00, parity=0 (from 0x03), less=1. Next beat PASS_A acc_sel=1 → acc=0x03, greater=1 vs b=0.
- ovf_clr asserted in the same cycle as an overflowing delivery → ovf_sticky=1. Then rst_n pulsed low while 2 beats are stalled → out_valid=0 immediately, accumulator 0, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared types for the pipelined ALU.
//   alu_op_e    - 3-bit operation select
//   alu_flags_t - status flags produced alongside every result
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_XOR    = 3'b100,
        OP_SHL    = 3'b101,
        OP_SHR    = 3'b110,
        OP_PASS_A = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic parity;
        logic overflow;
        logic greater;
        logic is_eq;
        logic less;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
// Ports:
//   a      in  WIDTH  effective operand A (already muxed with the accumulator)
//   b      in  WIDTH  operand B; b[SHW-1:0] is the shift amount for SHL/SHR
//   op     in  3      operation select (alu_op_e encoding)
//   result out WIDTH  unmasked result
//   flags  out        parity / signed overflow / unsigned compare flags
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_e          op_e;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sa;
    logic             sb;

    assign op_e  = alu_op_e'(op);
    assign shamt = b[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;
    assign sa    = a[WIDTH-1];
    assign sb    = b[WIDTH-1];

    always_comb begin
        result = '0;
        case (op_e)
            OP_ADD:    result = sum;
            OP_SUB:    result = diff;
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_SHL:    result = a << shamt;
            OP_SHR:    result = a >> shamt;
            OP_PASS_A: result = a;
            default:   result = '0;
        endcase
    end

    always_comb begin
        flags          = '0;
        flags.parity   = ^result;
        flags.greater  = (a > b);
        flags.is_eq    = (a == b);
        flags.less     = (a < b);
        // Signed overflow: operands share a sign (ADD) or differ in sign (SUB),
        // and the result's sign no longer matches A.
        case (op_e)
            OP_ADD:  flags.overflow = (sa == sb) && (sum[WIDTH-1] != sa);
            OP_SUB:  flags.overflow = (sa != sb) && (diff[WIDTH-1] != sa);
            default: flags.overflow = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage pipelined ALU with valid/ready on both sides,
// an accumulator operand mode and a sticky overflow flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (a, b, op, acc_sel, oe)
//   acc_sel             use the accumulator instead of a as operand A
//   oe                  0 forces y to zero for that beat (flags unaffected)
//   out_valid/out_ready result beat handshake
//   y, parity, overflow, greater, is_eq, less  registered result and flags
//   ovf_sticky/ovf_clr  sticky overflow flag and its synchronous clear
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             oe,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             parity,
    output logic             overflow,
    output logic             greater,
    output logic             is_eq,
    output logic             less,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    // Stage 1: captured operand beat
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             acc_sel_q, acc_sel_d;
    logic             oe_q, oe_d;
    logic             s1_valid_q, s1_valid_d;

    // Stage 2: registered result and flags
    logic [WIDTH-1:0] y_q, y_d;
    alu_flags_t       flags_q, flags_d;
    logic             s2_valid_q, s2_valid_d;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;
    logic             s12_fire;
    logic             out_fire;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_fire  = in_valid & s1_adv;
    assign s12_fire = s1_valid_q & s2_adv;
    assign out_fire = s2_valid_q & out_ready;

    // The accumulator is read at the S1->S2 transfer rather than at issue,
    // so it already holds the previous beat's result and chaining needs no
    // forwarding path.
    assign eff_a = acc_sel_q ? acc_q : a_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (eff_a),
        .b      (b_q),
        .op     (op_q),
        .result (core_result),
        .flags  (core_flags)
    );

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        acc_sel_d  = acc_sel_q;
        oe_d       = oe_q;
        s1_valid_d = s1_valid_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            a_d       = a;
            b_d       = b;
            op_d      = op;
            acc_sel_d = acc_sel;
            oe_d      = oe;
        end
    end

    always_comb begin
        y_d        = y_q;
        flags_d    = flags_q;
        acc_d      = acc_q;
        s2_valid_d = s2_valid_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s12_fire) begin
            y_d     = oe_q ? core_result : '0;
            flags_d = core_flags;
            acc_d   = core_result;
        end
    end

    // Set has priority over clear so an overflow delivered in the clear
    // cycle is never lost.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
        if (out_fire && flags_q.overflow) begin
            ovf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            acc_sel_q    <= 1'b0;
            oe_q         <= 1'b0;
            s1_valid_q   <= 1'b0;
            y_q          <= '0;
            flags_q      <= '0;
            s2_valid_q   <= 1'b0;
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            acc_sel_q    <= acc_sel_d;
            oe_q         <= oe_d;
            s1_valid_q   <= s1_valid_d;
            y_q          <= y_d;
            flags_q      <= flags_d;
            s2_valid_q   <= s2_valid_d;
            acc_q        <= acc_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign y          = y_q;
    assign parity     = flags_q.parity;
    assign overflow   = flags_q.overflow;
    assign greater    = flags_q.greater;
    assign is_eq      = flags_q.is_eq;
    assign less       = flags_q.less;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven check of alu_pipe at WIDTH=8, plus
// hand-written sequences for chaining, backpressure, sticky overflow and
// reset during a stall.
module tb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_sel;
    logic       oe;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       parity;
    logic       overflow;
    logic       greater;
    logic       is_eq;
    logic       less;
    logic       ovf_sticky;
    logic       ovf_clr;

    int n_cmp;
    int n_err;

    alu_pipe #(
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .acc_sel    (acc_sel),
        .oe         (oe),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .parity     (parity),
        .overflow   (overflow),
        .greater    (greater),
        .is_eq      (is_eq),
        .less       (less),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {parity, overflow, greater, is_eq, less}
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       acc_sel;
        logic       oe;
        logic [7:0] y;
        logic [4:0] fl;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    // advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic as, input logic e);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        acc_sel  = as;
        oe       = e;
    endtask

    function automatic logic [12:0] outs();
        return {y, parity, overflow, greater, is_eq, less};
    endfunction

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        acc_sel   = 1'b0;
        oe        = 1'b1;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;

        // Sequential table: the accumulator carries the previous unmasked result.
        //            op     a      b      acc oe  y      {par,ovf,gt,eq,lt}
        vecs[0]  = '{3'd0, 8'h7F, 8'h01, 0, 1, 8'h80, 5'b11100}; // ADD overflow
        vecs[1]  = '{3'd1, 8'h05, 8'h05, 0, 1, 8'h00, 5'b00010}; // SUB equal
        vecs[2]  = '{3'd5, 8'h81, 8'h03, 0, 1, 8'h08, 5'b10100}; // SHL by 3
        vecs[3]  = '{3'd3, 8'h01, 8'h02, 0, 0, 8'h00, 5'b00001}; // OR, oe=0 (true 0x03)
        vecs[4]  = '{3'd7, 8'h55, 8'h00, 1, 1, 8'h03, 5'b00100}; // PASS_A from acc
        vecs[5]  = '{3'd6, 8'hF0, 8'h04, 0, 1, 8'h0F, 5'b00100}; // SHR by 4
        vecs[6]  = '{3'd2, 8'hF0, 8'h3C, 0, 1, 8'h30, 5'b00100}; // AND
        vecs[7]  = '{3'd1, 8'h80, 8'h01, 0, 1, 8'h7F, 5'b11100}; // SUB overflow
        vecs[8]  = '{3'd1, 8'h01, 8'h02, 0, 1, 8'hFF, 5'b00001}; // SUB wrap, no ovf
        vecs[9]  = '{3'd0, 8'h00, 8'h01, 1, 1, 8'h00, 5'b00100}; // ADD acc(0xFF)+1 wraps
        vecs[10] = '{3'd4, 8'hAA, 8'h55, 0, 1, 8'hFF, 5'b00100}; // XOR
        vecs[11] = '{3'd0, 8'h80, 8'h80, 0, 1, 8'h00, 5'b01010}; // ADD neg overflow

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y_flags", 32'(outs()), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ---- table: one beat at a time, 2-cycle latency ----
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].acc_sel, vecs[i].oe);
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_y_flags", i), 32'(outs()), 32'({vecs[i].y, vecs[i].fl}));
        end
        step();
        check("sticky_set", 32'(ovf_sticky), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sticky_clear", 32'(ovf_sticky), 32'd0);

        // ---- accumulator chain, back-to-back ----
        drive(3'd0, 8'h03, 8'h04, 1'b0, 1'b1);
        step();
        drive(3'd0, 8'h00, 8'h0A, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        check("chain_v1", 32'(out_valid), 32'd1);
        check("chain_y1", 32'(y), 32'h07);
        step();
        check("chain_v2", 32'(out_valid), 32'd1);
        check("chain_y2", 32'(y), 32'h11);
        step();
        check("chain_drain", 32'(out_valid), 32'd0);

        // ---- backpressure ----
        out_ready = 1'b0;
        drive(3'd4, 8'h0F, 8'hF0, 1'b0, 1'b1);
        step();
        drive(3'd4, 8'hAA, 8'h55, 1'b0, 1'b1);
        check("bp_ready_2nd", 32'(in_ready), 32'd1);
        step();
        drive(3'd0, 8'h01, 8'h01, 1'b0, 1'b1);
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_y_a", 32'({out_valid, y}), 32'h1FF);
        step();
        check("bp_ready_hold", 32'(in_ready), 32'd0);
        check("bp_y_b", 32'({out_valid, y}), 32'h1FF);
        step();
        check("bp_y_c", 32'({out_valid, y}), 32'h1FF);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_out2", 32'({out_valid, y}), 32'h1FF);
        step();
        check("bp_out3", 32'({out_valid, y}), 32'h102);
        step();
        check("bp_drain", 32'(out_valid), 32'd0);

        // ---- set and clear in the same cycle: set wins ----
        drive(3'd0, 8'h7F, 8'h01, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        check("ovf_beat", 32'({out_valid, overflow}), 32'd3);
        ovf_clr = 1'b1;
        step();
        check("ovf_set_wins", 32'(ovf_sticky), 32'd1);
        step();
        ovf_clr = 1'b0;
        check("ovf_clr_after", 32'(ovf_sticky), 32'd0);

        // ---- asynchronous reset while two beats are stalled ----
        out_ready = 1'b0;
        drive(3'd0, 8'h10, 8'h20, 1'b0, 1'b1);
        step();
        drive(3'd0, 8'h01, 8'h01, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        check("stall_valid", 32'({out_valid, in_ready}), 32'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_y_flags", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        drive(3'd7, 8'h99, 8'h00, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        check("post_rst_acc", 32'({out_valid, y, is_eq}), 32'({1'b1, 8'h00, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
